// File: rtl/lsu_mem_stage.sv
// RV32I MEM stage: one outstanding req/ack data access, byte-lane steering, load extension, fault pulses.
// Optional ack timeout with bus_err reporting is compiled in when LSU_TIMEOUT_EN is defined.
module lsu_mem_stage #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [31:0] ex_alu_out,
    input  logic [31:0] ex_store_data,
    input  logic [2:0]  ex_funct3,
    input  logic        ex_is_load,
    input  logic        ex_is_store,
    input  logic [4:0]  ex_rd,
    input  logic        ex_reg_write,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        wb_reg_write,
    output logic        mem_fault,
    output logic        bus_err
);
    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] ACCESS = 1'b1;

    typedef struct packed {
        logic [2:0] funct3;
        logic [1:0] lane;
        logic [4:0] rd;
        logic       reg_write;
        logic       is_load;
    } pend_t;

    logic [0:0]  state;
    pend_t       pend;

    logic        is_mem;
    logic        legal;
    logic        misalign;
    logic        fault;
    logic [1:0]  a;
    logic [3:0]  be_n;
    logic [31:0] wdata_n;
    logic [31:0] lane_word;
    logic [31:0] load_val;
    logic        timeout;

    assign ex_ready = (state == IDLE);
    assign a        = ex_alu_out[1:0];

    always_comb begin
        is_mem   = ex_is_load | ex_is_store;
        legal    = 1'b0;
        case (ex_funct3)
            3'b000, 3'b001, 3'b010: legal = 1'b1;
            3'b100, 3'b101:         legal = ex_is_load;
            default:                legal = 1'b0;
        endcase
        misalign = ((ex_funct3[1:0] == 2'b01) && a[0]) ||
                   ((ex_funct3[1:0] == 2'b10) && (a != 2'b00));
        fault    = is_mem && (!legal || misalign || (ex_is_load && ex_is_store));

        be_n     = 4'b1111;
        wdata_n  = ex_store_data;
        case (ex_funct3[1:0])
            2'b00: begin
                be_n    = 4'b0001 << a;
                wdata_n = {4{ex_store_data[7:0]}};
            end
            2'b01: begin
                be_n    = 4'b0011 << a;
                wdata_n = {2{ex_store_data[15:0]}};
            end
            default: begin
                be_n    = 4'b1111;
                wdata_n = ex_store_data;
            end
        endcase
    end

    // Shift the addressed lane down to bit 0, then extend by size/sign.
    always_comb begin
        lane_word = dmem_rdata >> {pend.lane, 3'b000};
        case (pend.funct3)
            3'b000:  load_val = {{24{lane_word[7]}}, lane_word[7:0]};
            3'b001:  load_val = {{16{lane_word[15]}}, lane_word[15:0]};
            3'b100:  load_val = {24'd0, lane_word[7:0]};
            3'b101:  load_val = {16'd0, lane_word[15:0]};
            default: load_val = lane_word;
        endcase
    end

`ifdef LSU_TIMEOUT_EN
    logic [7:0] wait_cnt;

    // Fires on the edge where the count would reach the limit; an ack on that edge takes priority.
    assign timeout = (state == ACCESS) && !dmem_ack &&
                     (wait_cnt == 8'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt <= 8'd0;
        end else if (state == IDLE) begin
            wait_cnt <= 8'd0;
        end else if (!dmem_ack) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            pend         <= '0;
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            dmem_addr    <= 32'd0;
            dmem_wdata   <= 32'd0;
            dmem_be      <= 4'd0;
            wb_valid     <= 1'b0;
            wb_rd        <= 5'd0;
            wb_data      <= 32'd0;
            wb_reg_write <= 1'b0;
            mem_fault    <= 1'b0;
            bus_err      <= 1'b0;
        end else begin
            wb_valid  <= 1'b0;
            mem_fault <= 1'b0;
            bus_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (ex_valid) begin
                        if (!is_mem) begin
                            wb_valid     <= 1'b1;
                            wb_rd        <= ex_rd;
                            wb_data      <= ex_alu_out;
                            wb_reg_write <= ex_reg_write && (ex_rd != 5'd0);
                        end else if (fault) begin
                            wb_valid     <= 1'b1;
                            mem_fault    <= 1'b1;
                            wb_rd        <= ex_rd;
                            wb_data      <= 32'd0;
                            wb_reg_write <= 1'b0;
                        end else begin
                            state      <= ACCESS;
                            dmem_req   <= 1'b1;
                            dmem_we    <= ex_is_store;
                            dmem_addr  <= {ex_alu_out[31:2], 2'b00};
                            dmem_be    <= be_n;
                            dmem_wdata <= wdata_n;
                            pend       <= '{funct3: ex_funct3, lane: a, rd: ex_rd,
                                            reg_write: ex_reg_write, is_load: ex_is_load};
                        end
                    end
                end
                ACCESS: begin
                    if (dmem_ack) begin
                        state        <= IDLE;
                        dmem_req     <= 1'b0;
                        wb_valid     <= 1'b1;
                        wb_rd        <= pend.rd;
                        wb_data      <= pend.is_load ? load_val : 32'd0;
                        wb_reg_write <= pend.is_load && pend.reg_write && (pend.rd != 5'd0);
                    end else if (timeout) begin
                        state        <= IDLE;
                        dmem_req     <= 1'b0;
                        wb_valid     <= 1'b1;
                        bus_err      <= 1'b1;
                        wb_rd        <= pend.rd;
                        wb_data      <= 32'd0;
                        wb_reg_write <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_mem_stage.sv
// Scoreboard bench for lsu_mem_stage: expected writebacks are queued at issue and checked by a monitor.
module tb_lsu_mem_stage;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex_valid = 1'b0;
    logic        ex_ready;
    logic [31:0] ex_alu_out = '0;
    logic [31:0] ex_store_data = '0;
    logic [2:0]  ex_funct3 = '0;
    logic        ex_is_load = 1'b0;
    logic        ex_is_store = 1'b0;
    logic [4:0]  ex_rd = '0;
    logic        ex_reg_write = 1'b0;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack = 1'b0;
    logic [31:0] dmem_rdata = '0;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_reg_write;
    logic        mem_fault;
    logic        bus_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        chk_data;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        rw;
        logic        fault;
        logic        berr;
    } wb_exp_t;

    wb_exp_t sb[$];

    lsu_mem_stage dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_alu_out(ex_alu_out),
        .ex_store_data(ex_store_data), .ex_funct3(ex_funct3), .ex_is_load(ex_is_load),
        .ex_is_store(ex_is_store), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ack(dmem_ack),
        .dmem_rdata(dmem_rdata), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .wb_reg_write(wb_reg_write), .mem_fault(mem_fault), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    // Writeback monitor: every wb_valid pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (wb_valid) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL wb_unexpected: got rd=%0d data=%h rw=%b with nothing expected",
                         wb_rd, wb_data, wb_reg_write);
            end else begin
                wb_exp_t e;
                e = sb.pop_front();
                if (wb_reg_write !== e.rw || mem_fault !== e.fault || bus_err !== e.berr ||
                    (e.chk_data && (wb_rd !== e.rd || wb_data !== e.data))) begin
                    errors++;
                    $display("FAIL wb_record: got rd=%0d data=%h rw=%b fault=%b berr=%b, want rd=%0d data=%h rw=%b fault=%b berr=%b",
                             wb_rd, wb_data, wb_reg_write, mem_fault, bus_err,
                             e.rd, e.data, e.rw, e.fault, e.berr);
                end
            end
        end else if (mem_fault || bus_err) begin
            checks++;
            errors++;
            $display("FAIL pulse_without_wb: fault=%b berr=%b", mem_fault, bus_err);
        end
    end

    task automatic drive(input logic [2:0] f3, input logic ld, input logic st,
                         input logic [31:0] addr, input logic [31:0] sd,
                         input logic [4:0] rd, input logic rw);
        ex_valid      = 1'b1;
        ex_funct3     = f3;
        ex_is_load    = ld;
        ex_is_store   = st;
        ex_alu_out    = addr;
        ex_store_data = sd;
        ex_rd         = rd;
        ex_reg_write  = rw;
    endtask

    task automatic push(input logic cd, input logic [4:0] rd, input logic [31:0] d,
                        input logic rw, input logic f, input logic b);
        wb_exp_t e;
        e = '{chk_data: cd, rd: rd, data: d, rw: rw, fault: f, berr: b};
        sb.push_back(e);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (ex_ready !== 1'b1 || dmem_req !== 1'b0 || dmem_we !== 1'b0 || dmem_addr !== 32'd0 ||
            dmem_wdata !== 32'd0 || dmem_be !== 4'd0 || wb_valid !== 1'b0 || wb_rd !== 5'd0 ||
            wb_data !== 32'd0 || wb_reg_write !== 1'b0 || mem_fault !== 1'b0 || bus_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: ready=%b req=%b be=%b addr=%h wbv=%b wbd=%h fault=%b berr=%b, want ready=1 rest 0",
                     ex_ready, dmem_req, dmem_be, dmem_addr, wb_valid, wb_data, mem_fault, bus_err);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Issue one legal memory op, check the request, ack after `delay` extra cycles.
    task automatic mem_op(input string name, input logic [2:0] f3, input logic ld, input logic st,
                          input logic [31:0] addr, input logic [31:0] sd, input logic [4:0] rd,
                          input logic [31:0] rdata, input int delay,
                          input logic [31:0] e_addr, input logic [3:0] e_be,
                          input logic [31:0] e_wdata, input logic [31:0] e_wb, input logic e_rw);
        drive(f3, ld, st, addr, sd, rd, 1'b1);
        push(1'b1, rd, e_wb, e_rw, 1'b0, 1'b0);
        @(negedge clk);
        ex_valid = 1'b0;
        checks++;
        if (dmem_req !== 1'b1 || dmem_addr !== e_addr || dmem_be !== e_be || dmem_we !== st ||
            (st && dmem_wdata !== e_wdata) || ex_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s_req: req=%b addr=%h be=%b we=%b wdata=%h ready=%b, want req=1 addr=%h be=%b we=%b wdata=%h ready=0",
                     name, dmem_req, dmem_addr, dmem_be, dmem_we, dmem_wdata, ex_ready,
                     e_addr, e_be, st, e_wdata);
        end
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            checks++;
            if (dmem_req !== 1'b1 || dmem_addr !== e_addr || dmem_be !== e_be || wb_valid !== 1'b0) begin
                errors++;
                $display("FAIL %s_hold: req=%b addr=%h be=%b wbv=%b, want req=1 addr=%h be=%b wbv=0",
                         name, dmem_req, dmem_addr, dmem_be, wb_valid, e_addr, e_be);
            end
        end
        dmem_ack   = 1'b1;
        dmem_rdata = rdata;
        @(negedge clk);
        dmem_ack   = 1'b0;
        dmem_rdata = $urandom;
        checks++;
        if (wb_valid !== 1'b1 || dmem_req !== 1'b0 || ex_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_done: wbv=%b req=%b ready=%b, want 1 0 1", name, wb_valid, dmem_req, ex_ready);
        end
    endtask

    task automatic test_loads();
        mem_op("lw",  3'b010, 1, 0, 32'h100, 0, 5'd5, 32'hDEADBEEF, 2, 32'h100, 4'b1111, 0, 32'hDEADBEEF, 1);
        mem_op("lb",  3'b000, 1, 0, 32'h103, 0, 5'd6, 32'h80FF1234, 0, 32'h100, 4'b1000, 0, 32'hFFFFFF80, 1);
        mem_op("lbu", 3'b100, 1, 0, 32'h103, 0, 5'd6, 32'h80FF1234, 1, 32'h100, 4'b1000, 0, 32'h00000080, 1);
        mem_op("lh",  3'b001, 1, 0, 32'h102, 0, 5'd8, 32'h80FF1234, 0, 32'h100, 4'b1100, 0, 32'hFFFF80FF, 1);
        mem_op("lhu", 3'b101, 1, 0, 32'h100, 0, 5'd9, 32'h80FF9234, 0, 32'h100, 4'b0011, 0, 32'h00009234, 1);
        mem_op("lb1", 3'b000, 1, 0, 32'h101, 0, 5'd10, 32'h80FF1234, 0, 32'h100, 4'b0010, 0, 32'h00000012, 1);
        mem_op("lw_r0", 3'b010, 1, 0, 32'h104, 0, 5'd0, 32'h11112222, 0, 32'h104, 4'b1111, 0, 32'h11112222, 0);
    endtask

    task automatic test_stores();
        mem_op("sh", 3'b001, 0, 1, 32'h202, 32'h1234ABCD, 5'd7, 32'hFFFFFFFF, 1, 32'h200, 4'b1100, 32'hABCDABCD, 0, 0);
        mem_op("sb", 3'b000, 0, 1, 32'h105, 32'h000000CD, 5'd7, 32'hFFFFFFFF, 0, 32'h104, 4'b0010, 32'hCDCDCDCD, 0, 0);
        mem_op("sw", 3'b010, 0, 1, 32'h300, 32'hCAFEF00D, 5'd2, 32'h0, 0, 32'h300, 4'b1111, 32'hCAFEF00D, 0, 0);
    endtask

    task automatic fault_op(input string name, input logic [2:0] f3, input logic ld, input logic st,
                            input logic [31:0] addr);
        drive(f3, ld, st, addr, 32'h55AA55AA, 5'd9, 1'b1);
        push(1'b0, 5'd9, 32'd0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        ex_valid = 1'b0;
        checks++;
        if (dmem_req !== 1'b0 || mem_fault !== 1'b1 || wb_valid !== 1'b1 || ex_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s: req=%b fault=%b wbv=%b ready=%b, want 0 1 1 1",
                     name, dmem_req, mem_fault, wb_valid, ex_ready);
        end
        @(negedge clk);
        checks++;
        if (mem_fault !== 1'b0 || wb_valid !== 1'b0 || dmem_req !== 1'b0) begin
            errors++;
            $display("FAIL %s_pulse: fault=%b wbv=%b req=%b, want 0 0 0", name, mem_fault, wb_valid, dmem_req);
        end
    endtask

    task automatic test_faults();
        fault_op("flt_lw_mis", 3'b010, 1, 0, 32'h101);
        fault_op("flt_f3_011", 3'b011, 1, 0, 32'h100);
        fault_op("flt_lh_mis", 3'b001, 1, 0, 32'h103);
        fault_op("flt_sh_mis", 3'b001, 0, 1, 32'h203);
        fault_op("flt_st_f3",  3'b100, 0, 1, 32'h200);
        fault_op("flt_ld_st",  3'b010, 1, 1, 32'h200);
    endtask

    task automatic test_back_to_back();
        logic [31:0] d [4];
        logic [4:0]  r [4];
        d = '{32'h5, 32'h5, 32'h5, 32'h12345678};
        r = '{5'd3, 5'd3, 5'd3, 5'd0};
        for (int i = 0; i < 4; i++) begin
            drive(3'b010, 1'b0, 1'b0, d[i], 32'd0, r[i], 1'b1);
            push(1'b1, r[i], d[i], r[i] != 5'd0, 1'b0, 1'b0);
            @(negedge clk);
            checks++;
            if (ex_ready !== 1'b1 || wb_valid !== 1'b1 || dmem_req !== 1'b0) begin
                errors++;
                $display("FAIL b2b_%0d: ready=%b wbv=%b req=%b, want 1 1 0", i, ex_ready, wb_valid, dmem_req);
            end
        end
        ex_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end: wbv=%b, want 0", wb_valid);
        end
    endtask

    task automatic test_idle_ack();
        dmem_ack = 1'b1;
        @(negedge clk);
        dmem_ack = 1'b0;
        @(negedge clk);
        checks++;
        if (wb_valid !== 1'b0 || dmem_req !== 1'b0 || ex_ready !== 1'b1) begin
            errors++;
            $display("FAIL idle_ack: wbv=%b req=%b ready=%b, want 0 0 1", wb_valid, dmem_req, ex_ready);
        end
    endtask

    task automatic test_reset_mid_access();
        drive(3'b010, 1'b1, 1'b0, 32'h400, 32'd0, 5'd4, 1'b1);
        @(negedge clk);
        ex_valid = 1'b0;
        checks++;
        if (dmem_req !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_req: req=%b, want 1", dmem_req);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n    = 1'b1;
        dmem_ack = 1'b1;
        checks++;
        if (dmem_req !== 1'b0 || wb_valid !== 1'b0 || ex_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_drop: req=%b wbv=%b ready=%b, want 0 0 1", dmem_req, wb_valid, ex_ready);
        end
        @(negedge clk);
        dmem_ack = 1'b0;
        @(negedge clk);
        checks++;
        if (dmem_req !== 1'b0 || wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_late_ack: req=%b wbv=%b, want 0 0", dmem_req, wb_valid);
        end
    endtask

    task automatic test_timeout();
        drive(3'b010, 1'b1, 1'b0, 32'h500, 32'd0, 5'd11, 1'b1);
`ifdef LSU_TIMEOUT_EN
        push(1'b0, 5'd11, 32'd0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            ex_valid = 1'b0;
            checks++;
            if (dmem_req !== 1'b1 || bus_err !== 1'b0) begin
                errors++;
                $display("FAIL tmo_wait_%0d: req=%b berr=%b, want 1 0", i, dmem_req, bus_err);
            end
        end
        @(negedge clk);
        checks++;
        if (bus_err !== 1'b1 || wb_valid !== 1'b1 || dmem_req !== 1'b0 || ex_ready !== 1'b1) begin
            errors++;
            $display("FAIL tmo_fire: berr=%b wbv=%b req=%b ready=%b, want 1 1 0 1",
                     bus_err, wb_valid, dmem_req, ex_ready);
        end
        @(negedge clk);
`else
        push(1'b1, 5'd11, 32'h0BADF00D, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            ex_valid = 1'b0;
        end
        checks++;
        if (dmem_req !== 1'b1 || bus_err !== 1'b0 || ex_ready !== 1'b0) begin
            errors++;
            $display("FAIL no_tmo_wait: req=%b berr=%b ready=%b, want 1 0 0", dmem_req, bus_err, ex_ready);
        end
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h0BADF00D;
        @(negedge clk);
        dmem_ack = 1'b0;
        checks++;
        if (wb_valid !== 1'b1 || bus_err !== 1'b0) begin
            errors++;
            $display("FAIL no_tmo_ack: wbv=%b berr=%b, want 1 0", wb_valid, bus_err);
        end
        @(negedge clk);
`endif
    endtask

    initial begin
        test_reset();
        test_loads();
        test_stores();
        test_faults();
        test_back_to_back();
        test_idle_ack();
        test_reset_mid_access();
        test_timeout();
        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: %0d writebacks missing, want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
